// File: rtl/dds_ctrl_pkg.sv
// Shared types and defaults for the DDS waveform controller.
package dds_ctrl_pkg;

  localparam int PHASE_W_DEF = 32;
  localparam int ADDR_W_DEF  = 10;
  localparam int BURST_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_STOP_WAIT = 2'd2
  } state_e;

  localparam logic [1:0] WAVE_SINE     = 2'd0;
  localparam logic [1:0] WAVE_SQUARE   = 2'd1;
  localparam logic [1:0] WAVE_TRIANGLE = 2'd2;
  localparam logic [1:0] WAVE_SAW      = 2'd3;

endpackage

// File: rtl/dds_phase_acc.sv
// Phase accumulator: load has priority over add; wrap flags the carry of the pending add.
module dds_phase_acc
  import dds_ctrl_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF
) (
  input  logic               clk_125M,
  input  logic               rst_n,
  input  logic               load,
  input  logic               en,
  input  logic [PHASE_W-1:0] load_val,
  input  logic [PHASE_W-1:0] fword,
  output logic [ADDR_W-1:0]  addr,
  output logic               wrap
);

  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] sum;
  logic               carry;

  assign {carry, sum} = {1'b0, phase} + {1'b0, fword};
  assign wrap = en & carry;
  assign addr = phase[PHASE_W-1 -: ADDR_W];

  always_ff @(posedge clk_125M or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (load) begin
      phase <= load_val;
    end else if (en) begin
      phase <= sum;
    end
  end

endmodule

// File: rtl/dds_wave_ctrl.sv
// DDS waveform sequencer: config handshake, burst/continuous runs, graceful stop.
//   state        | meaning
//   ST_IDLE      | config accepted, phase parked at offset, DAC idle
//   ST_RUN       | accumulating, counting wraps against burst length
//   ST_STOP_WAIT | stop seen, finishing current period
module dds_wave_ctrl
  import dds_ctrl_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input  logic               clk_125M,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [PHASE_W-1:0] cfg_fword,
  input  logic [PHASE_W-1:0] cfg_phase,
  input  logic [1:0]         cfg_wave_sel,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic               start,
  input  logic               stop,
  output logic [ADDR_W+1:0]  rom_addr,
  output logic               da_en,
  output logic               busy,
  output logic               done
);

  state_e             state;
  logic [PHASE_W-1:0] fword_r;
  logic [PHASE_W-1:0] phase_off;
  logic [1:0]         wave_sel_r;
  logic [BURST_W-1:0] burst_r;
  logic [BURST_W-1:0] wrap_cnt;
  logic [ADDR_W-1:0]  acc_addr;
  logic               wrap;
  logic               accept;
  logic               burst_hit;
  logic               finish;
  logic               acc_load;
  logic [PHASE_W-1:0] load_val;

  assign cfg_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign da_en     = busy;
  assign accept    = cfg_valid & cfg_ready;
  assign rom_addr  = {wave_sel_r, acc_addr};

  // A start in the handshake cycle must see the offset being accepted, not the old one.
  assign load_val  = accept ? cfg_phase : phase_off;
  assign burst_hit = wrap && (burst_r != '0) && ((wrap_cnt + BURST_W'(1)) == burst_r);

  always_comb begin
    finish = 1'b0;
    case (state)
      ST_RUN:       finish = burst_hit | (stop & (wrap | (fword_r == '0)));
      ST_STOP_WAIT: finish = wrap;
      default:      finish = 1'b0;
    endcase
  end

  // Reload on the exit edge so the first IDLE cycle already shows the offset.
  assign acc_load = (state == ST_IDLE) | finish;

  dds_phase_acc #(
    .PHASE_W (PHASE_W),
    .ADDR_W  (ADDR_W)
  ) u_acc (
    .clk_125M (clk_125M),
    .rst_n    (rst_n),
    .load     (acc_load),
    .en       (busy),
    .load_val (load_val),
    .fword    (fword_r),
    .addr     (acc_addr),
    .wrap     (wrap)
  );

  always_ff @(posedge clk_125M or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      fword_r    <= '0;
      phase_off  <= '0;
      wave_sel_r <= WAVE_SINE;
      burst_r    <= '0;
      wrap_cnt   <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            fword_r    <= cfg_fword;
            phase_off  <= cfg_phase;
            wave_sel_r <= cfg_wave_sel;
            burst_r    <= cfg_burst;
          end
          if (start) begin
            state    <= ST_RUN;
            wrap_cnt <= '0;
          end
        end
        ST_RUN: begin
          if (wrap) wrap_cnt <= wrap_cnt + BURST_W'(1);
          if (finish) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end else if (stop) begin
            state <= ST_STOP_WAIT;
          end
        end
        ST_STOP_WAIT: begin
          if (finish) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_wave_ctrl.sv
// Self-checking bench for dds_wave_ctrl: vector table plus directed multi-cycle sequences.
module tb_dds_wave_ctrl;

  logic        clk_125M = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_fword;
  logic [31:0] cfg_phase;
  logic [1:0]  cfg_wave_sel;
  logic [15:0] cfg_burst;
  logic        start;
  logic        stop;
  logic [11:0] rom_addr;
  logic        da_en;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  always #4 clk_125M = ~clk_125M;

  dds_wave_ctrl dut (
    .clk_125M     (clk_125M),
    .rst_n        (rst_n),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_fword    (cfg_fword),
    .cfg_phase    (cfg_phase),
    .cfg_wave_sel (cfg_wave_sel),
    .cfg_burst    (cfg_burst),
    .start        (start),
    .stop         (stop),
    .rom_addr     (rom_addr),
    .da_en        (da_en),
    .busy         (busy),
    .done         (done)
  );

  typedef struct {
    logic        cv;
    logic [31:0] fw;
    logic [31:0] ph;
    logic [1:0]  ws;
    logic [15:0] bu;
    logic        st;
    logic        sp;
    logic [11:0] addr;
    logic        da;
    logic        dn;
    logic        rdy;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_125M);
    @(negedge clk_125M);
  endtask

  task automatic set_cfg(input logic v, input logic [31:0] fw, input logic [31:0] ph,
                         input logic [1:0] ws, input logic [15:0] bu);
    cfg_valid    = v;
    cfg_fword    = fw;
    cfg_phase    = ph;
    cfg_wave_sel = ws;
    cfg_burst    = bu;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int dn;
    logic [11:0] e;
    logic found;

    //            cv    fword          phase          ws    burst  st    sp    addr     da    dn    rdy
    vecs[0]  = '{1'b1, 32'h4000_0000, 32'h0800_0000, 2'd2, 16'd1, 1'b0, 1'b0, 12'h820, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 32'h0,         32'h0,         2'd0, 16'd0, 1'b1, 1'b0, 12'h820, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 32'h0,         32'h0,         2'd0, 16'd0, 1'b0, 1'b0, 12'h920, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 32'h0,         32'h0,         2'd0, 16'd0, 1'b0, 1'b0, 12'hA20, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 32'h0,         32'h0,         2'd0, 16'd0, 1'b0, 1'b0, 12'hB20, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 32'h0,         32'h0,         2'd0, 16'd0, 1'b0, 1'b0, 12'h820, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 32'h0,         32'h0,         2'd0, 16'd0, 1'b0, 1'b0, 12'h820, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 32'h8000_0000, 32'h0,         2'd1, 16'd2, 1'b1, 1'b0, 12'h400, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 32'h0,         32'h0,         2'd3, 16'd0, 1'b0, 1'b0, 12'h600, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 32'h0,         32'h0,         2'd0, 16'd0, 1'b0, 1'b0, 12'h400, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 32'h0,         32'h0,         2'd0, 16'd0, 1'b0, 1'b0, 12'h600, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 32'h0,         32'h0,         2'd0, 16'd0, 1'b0, 1'b0, 12'h400, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 32'h0,         32'h0,         2'd0, 16'd0, 1'b0, 1'b1, 12'h400, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0;
    set_cfg(1'b0, 32'h0, 32'h0, 2'd0, 16'd0);
    start = 1'b0;
    stop  = 1'b0;
    repeat (3) @(negedge clk_125M);
    check("reset_rom_addr", 32'(rom_addr), 32'h0);
    check("reset_da_en", 32'(da_en), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    rst_n = 1'b1;
    tick();
    check("post_reset_cfg_ready", 32'(cfg_ready), 32'h1);

    for (int i = 0; i < 13; i++) begin
      set_cfg(vecs[i].cv, vecs[i].fw, vecs[i].ph, vecs[i].ws, vecs[i].bu);
      start = vecs[i].st;
      stop  = vecs[i].sp;
      tick();
      check($sformatf("vec%0d_rom_addr", i), 32'(rom_addr), 32'(vecs[i].addr));
      check($sformatf("vec%0d_da_en", i), 32'(da_en), 32'(vecs[i].da));
      check($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].dn));
      check($sformatf("vec%0d_cfg_ready", i), 32'(cfg_ready), 32'(vecs[i].rdy));
    end
    set_cfg(1'b0, 32'h0, 32'h0, 2'd0, 16'd0);
    start = 1'b0;
    stop  = 1'b0;

    // Continuous sweep: one address step per cycle, wraps after 1024.
    set_cfg(1'b1, 32'h0040_0000, 32'h0, 2'd0, 16'd0);
    start = 1'b1;
    tick();
    set_cfg(1'b0, 32'h0, 32'h0, 2'd0, 16'd0);
    start = 1'b0;
    for (int i = 0; i < 1030; i++) begin
      e = 12'(i % 1024);
      check("sweep_rom_addr", 32'(rom_addr), 32'(e));
      check("sweep_da_en", 32'(da_en), 32'h1);
      tick();
    end

    // Asynchronous reset in the middle of the run.
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_rom_addr", 32'(rom_addr), 32'h0);
    check("midrst_da_en", 32'(da_en), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_done", 32'(done), 32'h0);
    repeat (2) begin
      @(negedge clk_125M);
      check("midrst_hold_done", 32'(done), 32'h0);
    end
    rst_n = 1'b1;
    tick();
    check("midrst_release_done", 32'(done), 32'h0);
    check("midrst_release_ready", 32'(cfg_ready), 32'h1);

    // Burst of 3 periods at 16 samples each.
    set_cfg(1'b1, 32'h1000_0000, 32'h0, 2'd1, 16'd3);
    start = 1'b1;
    tick();
    set_cfg(1'b0, 32'h0, 32'h0, 2'd0, 16'd0);
    start = 1'b0;
    n  = 0;
    dn = 0;
    for (int k = 0; k < 200 && busy; k++) begin
      if (done) dn++;
      n++;
      tick();
    end
    check("burst_run_cycles", 32'(n), 32'd48);
    check("burst_done_at_exit", 32'(done), 32'h1);
    check("burst_busy_after", 32'(busy), 32'h0);
    check("burst_ready_after", 32'(cfg_ready), 32'h1);
    for (int k = 0; k < 4; k++) begin
      if (done) dn++;
      tick();
    end
    check("burst_done_count", 32'(dn), 32'd1);

    // Graceful stop mid-period; config offers during RUN must be ignored.
    set_cfg(1'b1, 32'h1000_0000, 32'h0, 2'd0, 16'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    set_cfg(1'b1, 32'h0, 32'h0, 2'd3, 16'd0);
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (rom_addr == 12'h140) begin
        found = 1'b1;
        break;
      end
      check("run_cfg_ready_low", 32'(cfg_ready), 32'h0);
      check("run_bank_unchanged", 32'(rom_addr[11:10]), 32'h0);
      tick();
    end
    check("stop_reached_0x140", 32'(found), 32'h1);
    set_cfg(1'b0, 32'h0, 32'h0, 2'd0, 16'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    e = 12'h180;
    for (int k = 0; k < 10; k++) begin
      check("stopwait_rom_addr", 32'(rom_addr), 32'(e));
      check("stopwait_busy", 32'(busy), 32'h1);
      check("stopwait_done", 32'(done), 32'h0);
      tick();
      e = e + 12'h040;
    end
    check("stop_exit_done", 32'(done), 32'h1);
    check("stop_exit_busy", 32'(busy), 32'h0);
    check("stop_exit_rom_addr", 32'(rom_addr), 32'h0);
    check("stop_exit_ready", 32'(cfg_ready), 32'h1);

    // Zero tuning word: stop leaves on the next cycle.
    set_cfg(1'b1, 32'h0, 32'h8000_0000, 2'd2, 16'd0);
    start = 1'b1;
    tick();
    set_cfg(1'b0, 32'h0, 32'h0, 2'd0, 16'd0);
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("fw0_rom_addr", 32'(rom_addr), 32'hA00);
      check("fw0_busy", 32'(busy), 32'h1);
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("fw0_stop_busy", 32'(busy), 32'h0);
    check("fw0_stop_done", 32'(done), 32'h1);
    check("fw0_stop_rom_addr", 32'(rom_addr), 32'hA00);
    tick();
    check("fw0_done_single", 32'(done), 32'h0);

    // Third burst wrap coinciding with stop: one done, straight to IDLE.
    set_cfg(1'b1, 32'h4000_0000, 32'h0, 2'd0, 16'd3);
    start = 1'b1;
    tick();
    set_cfg(1'b0, 32'h0, 32'h0, 2'd0, 16'd0);
    start = 1'b0;
    for (int k = 0; k < 11; k++) begin
      check("coinc_busy", 32'(busy), 32'h1);
      tick();
    end
    check("coinc_last_addr", 32'(rom_addr), 32'h300);
    check("coinc_last_busy", 32'(busy), 32'h1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("coinc_exit_busy", 32'(busy), 32'h0);
    check("coinc_exit_done", 32'(done), 32'h1);
    dn = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (done) dn++;
    end
    check("coinc_extra_done", 32'(dn), 32'd0);
    check("coinc_idle_busy", 32'(busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
